// File: rtl/ems_pkg.sv
// Shared types and constants for the LIM-EMS page mapper: page/register
// formats, the four selectable frame bases and the memory-cycle FSM states.
package ems_pkg;

    localparam int EMS_PAGE_BITS   = 7;
    localparam int EMS_NUM_WINDOWS = 4;

    typedef logic [EMS_PAGE_BITS-1:0] ems_page_t;

    // Page register layout as seen on the I/O port: bit7 enable, bits6:0 page.
    typedef struct packed {
        logic      enable;
        ems_page_t page;
    } ems_reg_t;

    typedef enum logic {
        EMS_IDLE   = 1'b0,
        EMS_ACTIVE = 1'b1
    } ems_state_t;

    // Frame base selected by ems_address; all bases are 16 KB aligned.
    localparam logic [19:0] EMS_FRAME_BASE [4] = '{
        20'hC0000,
        20'hD0000,
        20'hE0000,
        20'hC8000
    };

    // One-hot window select, bit N corresponds to ems_b(N+1).
    function automatic logic [3:0] ems_onehot(input logic [1:0] win);
        return 4'b0001 << win;
    endfunction

endpackage

// File: rtl/ems_window_decode.sv
// Combinational frame-window decoder. Only the 16 KB granule of the bus
// address matters because every frame base is 16 KB aligned, so the decode
// works on address[19:14].
module ems_window_decode
    import ems_pkg::*;
(
    input  logic [19:14] address,
    input  logic [1:0]   ems_address,
    output logic         hit,
    output logic [1:0]   win
);

    logic [5:0] base_granule;
    logic [6:0] granule_diff;

    // Distance from the frame base in 16 KB units; a borrow or a distance of
    // four or more granules means the address lies outside the 64 KB frame.
    always_comb begin
        base_granule = EMS_FRAME_BASE[ems_address][19:14];
        granule_diff = {1'b0, address} - {1'b0, base_granule};
        hit          = (granule_diff[6:2] == 5'd0);
        win          = granule_diff[1:0];
    end

endmodule

// File: rtl/ems_page_mapper.sv
// LIM-EMS page-register file and frame-window translator. Four I/O ports
// hold {enable, page} per window; memory cycles that fall inside the 64 KB
// frame raise one of ems_b1..ems_b4 so the RAM block can substitute the
// SDRAM address using map_ems/ena_ems.
module ems_page_mapper
    import ems_pkg::*;
#(
    parameter logic [15:0] IO_BASE     = 16'h0260,
    parameter int          PAGE_BITS   = EMS_PAGE_BITS,
    parameter int          NUM_WINDOWS = EMS_NUM_WINDOWS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ems_enabled,
    input  logic [1:0]  ems_address,
    input  logic [19:0] address,
    input  logic [7:0]  internal_data_bus,
    input  logic        address_enable_n,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_out_from_chipset,
    output ems_page_t   map_ems [0:3],
    output logic        ena_ems [0:3],
    output logic        ems_b1,
    output logic        ems_b2,
    output logic        ems_b3,
    output logic        ems_b4
);

    // Page register file
    ems_reg_t   regs_reg [4];

    // I/O write capture
    logic       io_write_q;
    logic       wr_pending_reg;
    logic [1:0] wr_idx_reg;
    logic [7:0] wr_data_reg;
    logic       wr_commit;

    // Read-back
    logic [7:0] data_bus_out_reg;
    logic       from_chipset_reg;

    // Memory-cycle FSM
    ems_state_t state_reg;
    logic [3:0] ems_b_reg;

    // Decode
    logic       port_hit;
    logic [1:0] port_idx;
    logic       win_hit;
    logic [1:0] win_idx;

    assign port_hit = ems_enabled && address_enable_n &&
                      (address[15:2] == IO_BASE[15:2]);
    assign port_idx = address[1:0];

    ems_window_decode u_window_decode (
        .address     (address[19:14]),
        .ems_address (ems_address),
        .hit         (win_hit),
        .win         (win_idx)
    );

    // Track the write strobe and latch address/data on every low cycle so the
    // commit uses the values present just before the strobe rose.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_write_q     <= 1'b1;
            wr_pending_reg <= 1'b0;
            wr_idx_reg     <= 2'd0;
            wr_data_reg    <= 8'h00;
        end else begin
            io_write_q <= io_write_n;
            if (!io_write_n) begin
                wr_pending_reg <= port_hit;
                wr_idx_reg     <= port_idx;
                wr_data_reg    <= internal_data_bus;
            end
        end
    end

    assign wr_commit = !io_write_q && io_write_n && wr_pending_reg;

    // Page registers update on the rising edge of the write strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_reg[wr_idx_reg] <= ems_reg_t'(wr_data_reg);
        end
    end

    // Read-back drives the chipset data path for as long as the read strobe
    // stays low on a page port, and parks the bus at zero otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_bus_out_reg <= 8'h00;
            from_chipset_reg <= 1'b0;
        end else if (!io_read_n && port_hit) begin
            data_bus_out_reg <= regs_reg[port_idx];
            from_chipset_reg <= 1'b1;
        end else begin
            data_bus_out_reg <= 8'h00;
            from_chipset_reg <= 1'b0;
        end
    end

    // Window hit is evaluated once at the start of a memory cycle and frozen
    // until both strobes go high, so mid-cycle address or mapping changes do
    // not glitch the SDRAM address substitution.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= EMS_IDLE;
            ems_b_reg <= 4'b0000;
        end else begin
            case (state_reg)
                EMS_IDLE: begin
                    if (ems_enabled && (!memory_read_n || !memory_write_n)) begin
                        state_reg <= EMS_ACTIVE;
                        ems_b_reg <= (win_hit && regs_reg[win_idx].enable) ?
                                     ems_onehot(win_idx) : 4'b0000;
                    end
                end
                EMS_ACTIVE: begin
                    if (!ems_enabled || (memory_read_n && memory_write_n)) begin
                        state_reg <= EMS_IDLE;
                        ems_b_reg <= 4'b0000;
                    end
                end
                default: begin
                    state_reg <= EMS_IDLE;
                    ems_b_reg <= 4'b0000;
                end
            endcase
        end
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_map_out
        assign map_ems[gi] = regs_reg[gi].page;
        assign ena_ems[gi] = regs_reg[gi].enable;
    end

    assign data_bus_out              = data_bus_out_reg;
    assign data_bus_out_from_chipset = from_chipset_reg;
    assign ems_b1                    = ems_b_reg[0];
    assign ems_b2                    = ems_b_reg[1];
    assign ems_b3                    = ems_b_reg[2];
    assign ems_b4                    = ems_b_reg[3];

    // The window structure is hard-wired to four windows of the package page width.
    a_geometry: assert property (@(posedge clock)
        (NUM_WINDOWS == EMS_NUM_WINDOWS) && (PAGE_BITS == EMS_PAGE_BITS));

    // At most one window may be flagged in any memory cycle.
    a_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(ems_b_reg));

endmodule

// File: tb/tb_ems_page_mapper.sv
// Self-checking bench for ems_page_mapper: a table of I/O and memory
// transactions plus hand-written multi-cycle sequences, with expectations
// queued when stimulus is driven and compared when the DUT responds.
module tb_ems_page_mapper;
    import ems_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ems_enabled;
    logic [1:0]  ems_address;
    logic [19:0] address;
    logic [7:0]  internal_data_bus;
    logic        address_enable_n;
    logic        io_read_n;
    logic        io_write_n;
    logic        memory_read_n;
    logic        memory_write_n;
    logic [7:0]  data_bus_out;
    logic        data_bus_out_from_chipset;
    ems_page_t   map_ems [0:3];
    logic        ena_ems [0:3];
    logic        ems_b1, ems_b2, ems_b3, ems_b4;

    always #5 clock = ~clock;

    ems_page_mapper dut (
        .clock                     (clock),
        .reset                     (reset),
        .ems_enabled               (ems_enabled),
        .ems_address               (ems_address),
        .address                   (address),
        .internal_data_bus         (internal_data_bus),
        .address_enable_n          (address_enable_n),
        .io_read_n                 (io_read_n),
        .io_write_n                (io_write_n),
        .memory_read_n             (memory_read_n),
        .memory_write_n            (memory_write_n),
        .data_bus_out              (data_bus_out),
        .data_bus_out_from_chipset (data_bus_out_from_chipset),
        .map_ems                   (map_ems),
        .ena_ems                   (ena_ems),
        .ems_b1                    (ems_b1),
        .ems_b2                    (ems_b2),
        .ems_b3                    (ems_b3),
        .ems_b4                    (ems_b4)
    );

    typedef enum int {OP_WR, OP_RD, OP_MEM_RD, OP_MEM_WR, OP_FRAME, OP_MAP} op_t;

    typedef struct {
        op_t         op;
        logic [19:0] addr;
        logic [7:0]  data;
        logic [8:0]  exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input op_t op, input logic [19:0] a, input logic [7:0] d,
                       input logic [8:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic expect_push(input string name, input logic [8:0] e);
        sb_t s;
        s.name = name; s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic observe(input logic [8:0] act);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %h", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s got %h expected %h", s.name, act, s.exp);
            end else begin
                $display("ok   %s = %h", s.name, act);
            end
        end
    endtask

    function automatic logic [8:0] ems_b_word();
        return {5'b0, ems_b4, ems_b3, ems_b2, ems_b1};
    endfunction

    function automatic logic [8:0] map_word(input int idx);
        return {1'b0, ena_ems[idx], map_ems[idx]};
    endfunction

    function automatic logic [8:0] rd_word();
        return {data_bus_out_from_chipset, data_bus_out};
    endfunction

    task automatic io_write(input logic [19:0] a, input logic [7:0] d);
        @(negedge clock);
        address = a; internal_data_bus = d; io_write_n = 1'b0;
        @(negedge clock);
        io_write_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic io_read(input logic [19:0] a, input string name, input logic [8:0] e);
        expect_push(name, e);
        @(negedge clock);
        address = a; io_read_n = 1'b0;
        @(negedge clock);
        observe(rd_word());
        io_read_n = 1'b1;
        expect_push({name, "_release"}, 9'h000);
        @(negedge clock);
        observe(rd_word());
    endtask

    task automatic mem_cycle(input logic [19:0] a, input logic is_write,
                             input string name, input logic [8:0] e);
        expect_push(name, e);
        @(negedge clock);
        address = a;
        if (is_write) memory_write_n = 1'b0;
        else          memory_read_n  = 1'b0;
        @(negedge clock);
        observe(ems_b_word());
        memory_read_n = 1'b1; memory_write_n = 1'b1;
        expect_push({name, "_end"}, 9'h000);
        @(negedge clock);
        observe(ems_b_word());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ems_enabled = 1'b1; ems_address = 2'd0; address = 20'h0;
        internal_data_bus = 8'h00; address_enable_n = 1'b1;
        io_read_n = 1'b1; io_write_n = 1'b1;
        memory_read_n = 1'b1; memory_write_n = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        for (int i = 0; i < 4; i++) begin
            expect_push($sformatf("reset_map%0d", i), 9'h000);
            observe(map_word(i));
        end
        expect_push("reset_readback", 9'h000); observe(rd_word());
        expect_push("reset_ems_b", 9'h000);    observe(ems_b_word());
        reset = 1'b0;

        // Transaction table: {op, address, data, expected}
        add(OP_WR,     20'h00261, 8'h85, 9'h000);
        add(OP_MAP,    20'h00001, 8'h00, 9'h085);
        add(OP_RD,     20'h00261, 8'h00, 9'h185);
        add(OP_RD,     20'h00260, 8'h00, 9'h100);
        add(OP_RD,     20'h00262, 8'h00, 9'h100);
        add(OP_RD,     20'h00263, 8'h00, 9'h100);
        add(OP_RD,     20'h00264, 8'h00, 9'h000);
        add(OP_RD,     20'h0025F, 8'h00, 9'h000);
        add(OP_WR,     20'h00260, 8'h83, 9'h000);
        add(OP_MAP,    20'h00000, 8'h00, 9'h083);
        add(OP_MEM_RD, 20'hC0123, 8'h00, 9'h001);
        add(OP_MEM_RD, 20'hC4000, 8'h00, 9'h002);
        add(OP_WR,     20'h00261, 8'h05, 9'h000);
        add(OP_MAP,    20'h00001, 8'h00, 9'h005);
        add(OP_MEM_RD, 20'hC4000, 8'h00, 9'h000);
        add(OP_MEM_RD, 20'hBFFFF, 8'h00, 9'h000);
        add(OP_MEM_WR, 20'hCFFFF, 8'h00, 9'h000);
        add(OP_FRAME,  20'h00000, 8'h02, 9'h000);
        add(OP_WR,     20'h00263, 8'h8A, 9'h000);
        add(OP_MEM_WR, 20'hEFFFF, 8'h00, 9'h008);
        add(OP_MEM_WR, 20'hF0000, 8'h00, 9'h000);
        add(OP_MEM_RD, 20'hE0000, 8'h00, 9'h001);
        add(OP_FRAME,  20'h00000, 8'h03, 9'h000);
        add(OP_WR,     20'h00262, 8'h81, 9'h000);
        add(OP_MEM_RD, 20'hD4000, 8'h00, 9'h008);
        add(OP_MEM_RD, 20'hD7FFF, 8'h00, 9'h008);
        add(OP_MEM_RD, 20'hD0000, 8'h00, 9'h004);
        add(OP_MEM_RD, 20'hC8000, 8'h00, 9'h001);
        add(OP_MEM_RD, 20'hC7FFF, 8'h00, 9'h000);
        add(OP_MEM_RD, 20'hD8000, 8'h00, 9'h000);
        add(OP_WR,     20'h00264, 8'hFF, 9'h000);
        add(OP_MAP,    20'h00000, 8'h00, 9'h083);
        add(OP_MAP,    20'h00003, 8'h00, 9'h08A);

        foreach (vecs[k]) begin
            case (vecs[k].op)
                OP_WR:     io_write(vecs[k].addr, vecs[k].data);
                OP_RD:     io_read(vecs[k].addr, $sformatf("v%0d_rd_%h", k, vecs[k].addr), vecs[k].exp);
                OP_MEM_RD: mem_cycle(vecs[k].addr, 1'b0, $sformatf("v%0d_mrd_%h", k, vecs[k].addr), vecs[k].exp);
                OP_MEM_WR: mem_cycle(vecs[k].addr, 1'b1, $sformatf("v%0d_mwr_%h", k, vecs[k].addr), vecs[k].exp);
                OP_FRAME:  begin @(negedge clock); ems_address = vecs[k].data[1:0]; end
                OP_MAP: begin
                    expect_push($sformatf("v%0d_map%0d", k, vecs[k].addr[1:0]), vecs[k].exp);
                    observe(map_word(int'(vecs[k].addr[1:0])));
                end
                default: ;
            endcase
        end

        // Page rewrite while a memory cycle is active on window 2
        @(negedge clock);
        ems_address = 2'd2; address = 20'hE8000; memory_read_n = 1'b0;
        expect_push("active_start", 9'h004);
        @(negedge clock); observe(ems_b_word());
        address = 20'h00262; internal_data_bus = 8'h00; io_write_n = 1'b0;
        @(negedge clock); io_write_n = 1'b1;
        @(negedge clock);
        expect_push("active_held", 9'h004);     observe(ems_b_word());
        expect_push("active_map2_new", 9'h000); observe(map_word(2));
        memory_read_n = 1'b1;
        expect_push("active_end", 9'h000);
        @(negedge clock); observe(ems_b_word());
        mem_cycle(20'hE8000, 1'b0, "after_rewrite", 9'h000);

        // DMA-owned bus and disabled EMS
        address_enable_n = 1'b0;
        io_write(20'h00263, 8'h00);
        address_enable_n = 1'b1;
        expect_push("dma_write_ignored", 9'h08A); observe(map_word(3));
        ems_enabled = 1'b0;
        io_read(20'h00261, "disabled_rd", 9'h000);
        mem_cycle(20'hEFFFF, 1'b1, "disabled_mem", 9'h000);
        io_write(20'h00260, 8'h00);
        ems_enabled = 1'b1;
        expect_push("disabled_write_ignored", 9'h083); observe(map_word(0));

        // EMS disabled in the middle of a hitting cycle
        @(negedge clock);
        address = 20'hEFFFF; memory_write_n = 1'b0;
        expect_push("drop_start", 9'h008);
        @(negedge clock); observe(ems_b_word());
        ems_enabled = 1'b0;
        expect_push("drop_cleared", 9'h000);
        @(negedge clock); observe(ems_b_word());
        memory_write_n = 1'b1; ems_enabled = 1'b1;
        @(negedge clock);
        expect_push("drop_regs_kept", 9'h08A); observe(map_word(3));

        // Reset during a hitting memory read
        @(negedge clock);
        ems_address = 2'd0; address = 20'hC0123; memory_read_n = 1'b0;
        expect_push("rst_start", 9'h001);
        @(negedge clock); observe(ems_b_word());
        reset = 1'b1;
        @(negedge clock);
        expect_push("rst_ems_b", 9'h000); observe(ems_b_word());
        for (int i = 0; i < 4; i++) begin
            expect_push($sformatf("rst_map%0d", i), 9'h000);
            observe(map_word(i));
        end
        reset = 1'b0; memory_read_n = 1'b1;
        @(negedge clock);

        // Reset discards a write whose strobe has not yet risen
        @(negedge clock);
        address = 20'h00261; internal_data_bus = 8'hFF; io_write_n = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0; io_write_n = 1'b1;
        repeat (2) @(negedge clock);
        expect_push("rst_write_discarded", 9'h000); observe(map_word(1));
        io_read(20'h00260, "rst_rd260", 9'h100);

        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
